new_cache_control: RTL and testbench
====================================

NEW_CACHE_CONTROL -- requirements
Module: new_cache_control

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 2 ways, 8 sets, 32-byte lines.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 mem_read  input  1  CPU/bus-adapter read request, held until mem_resp.
REQ-005 mem_write  input  1  CPU/bus-adapter write request, held until mem_resp.
REQ-006 mem_resp  output  1  one-cycle completion pulse to CPU.
REQ-007 pmem_read  output  1  line fill request to cacheline adapter.
REQ-008 pmem_write  output  1  line writeback request to cacheline adapter.
REQ-009 pmem_resp  input  1  cacheline adapter completion pulse.
REQ-010 miss, dirty_out, way  input  1 each  datapath status: no tag hit in set; dirty bit of selected way; selected way (hit way on hit, LRU way on miss).
REQ-011 data_in_sel  output  1  0 = pmem_rdata, 1 = mem_wdata256.
REQ-012 pmem_addr_sel  output  1  0 = writeback address {stored tag, index}, 1 = CPU address.
REQ-013 wr_en_data_0_sel, wr_en_data_1_sel  output  2 each  00 none, 01 full line, 10 CPU byte enables.
REQ-014 dirty_in, valid_in  output  1 each  data written to dirty/valid arrays.
REQ-015 ld_dirty_0, ld_dirty_1, ld_valid_0, ld_valid_1, ld_tag_0, ld_tag_1, ld_lru  output  1 each  array load strobes.

Function
REQ-016 FSM states SHALL be IDLE, CHECK, WRITEBACK, FETCH; every output not stated active below SHALL be 0.
REQ-017 IDLE: if mem_read or mem_write, next state CHECK; else stay.
REQ-018 CHECK, request gone: return to IDLE, no mem_resp, no array loads.
REQ-019 CHECK, ~miss, read: assert mem_resp and ld_lru; next IDLE.
REQ-020 CHECK, ~miss, write: data_in_sel=1, wr_en_data_<way>_sel=10, ld_dirty_<way>=1 with dirty_in=1, ld_lru=1, mem_resp=1; next IDLE.
REQ-021 mem_read and mem_write together SHALL be handled as a write.
REQ-022 CHECK, miss: next WRITEBACK if dirty_out=1, else FETCH; no outputs asserted.
REQ-023 WRITEBACK: pmem_write=1, pmem_addr_sel=0 every cycle until pmem_resp; on pmem_resp, ld_dirty_<way>=1 with dirty_in=0, next FETCH.
REQ-024 FETCH: pmem_read=1, pmem_addr_sel=1, data_in_sel=0 until pmem_resp; on pmem_resp, wr_en_data_<way>_sel=01, ld_tag_<way>=1, ld_valid_<way>=1 (valid_in=1), ld_dirty_<way>=1 (dirty_in=0), next CHECK.
REQ-025 <way> SHALL be the way input sampled in the same cycle; only that way's strobes/select assert.
REQ-026 Latency: hit mem_resp one cycle after request first seen in IDLE; clean miss = FETCH duration + 2 cycles; dirty miss adds WRITEBACK duration.
REQ-027 pmem_read and pmem_write SHALL never be asserted together and SHALL stay asserted, unchanged, until pmem_resp.
REQ-028 Once WRITEBACK or FETCH is entered, it SHALL complete even if the CPU request deasserts; REQ-018 then applies in CHECK.
REQ-029 pmem_resp outside WRITEBACK/FETCH SHALL be ignored.
REQ-030 mem_resp SHALL assert only in CHECK and for exactly one cycle per request.
REQ-031 A request still held in IDLE after mem_resp SHALL be treated as a new request.
REQ-032 Requester SHALL hold mem_address, mem_wdata256, mem_byte_enable256 stable from request to mem_resp.

Reset
REQ-033 rst SHALL force state IDLE at the next clock edge, overriding all transitions, including mid-WRITEBACK/FETCH.
REQ-034 In reset and the first cycle after, all outputs SHALL be 0; array contents are cleared by the datapath arrays' own rst.

Structure
REQ-035 Package new_cache_types SHALL hold the state enum and the wr_en select encodings (WREN_NONE=00, WREN_ALL=01, WREN_BYTE=10).
REQ-036 Single module: one state register, one next-state block, one output block; no sub-module; instantiated beside new_cache_datapath in the cache top.

Verification
REQ-037 Cold read 0x0000_0040 after reset: miss, dirty_out=0 -> FETCH, pmem_read, pmem_addr_sel=1; pmem_resp -> wr_en 01, tag/valid load -> CHECK hit -> mem_resp, ld_lru.
REQ-038 Read hit on same address -> mem_resp in cycle after request, no pmem_read.
REQ-039 Write hit, byte enable 0x0000_000F -> wr_en sel 10 on hit way, data_in_sel=1, dirty_in=1, mem_resp one cycle.
REQ-040 Dirty eviction: third tag in set 2 with LRU way dirty -> WRITEBACK (pmem_addr_sel=0) held 5 cycles until pmem_resp, dirty cleared, then FETCH, then mem_resp; pmem_read/pmem_write never overlap.
REQ-041 rst asserted in 3rd FETCH cycle -> next cycle IDLE, pmem_read=0, mem_resp=0; later pmem_resp ignored.
REQ-042 Request dropped during FETCH -> fill completes, CHECK returns IDLE without mem_resp.

Source files
------------

// File: rtl/new_cache_control_pkg.sv
// Shared types for the 2-way, 8-set cache controller: FSM state encoding and
// data-array write-enable select codes.
package new_cache_types;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_CHECK     = 2'd1,
        S_WRITEBACK = 2'd2,
        S_FETCH     = 2'd3
    } state_e;

    localparam logic [1:0] WREN_NONE = 2'b00;
    localparam logic [1:0] WREN_ALL  = 2'b01;
    localparam logic [1:0] WREN_BYTE = 2'b10;

endpackage

// File: rtl/new_cache_control_if.sv
// Control/status bundle between the cache controller, the CPU side, the
// cacheline adapter and the cache datapath.
interface new_cache_control_if;
    logic       mem_read;
    logic       mem_write;
    logic       mem_resp;
    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_resp;
    logic       miss;
    logic       dirty_out;
    logic       way;
    logic       data_in_sel;
    logic       pmem_addr_sel;
    logic [1:0] wr_en_data_0_sel;
    logic [1:0] wr_en_data_1_sel;
    logic       dirty_in;
    logic       valid_in;
    logic       ld_dirty_0;
    logic       ld_dirty_1;
    logic       ld_valid_0;
    logic       ld_valid_1;
    logic       ld_tag_0;
    logic       ld_tag_1;
    logic       ld_lru;

    // Controller side
    modport master (
        input  mem_read, mem_write, pmem_resp, miss, dirty_out, way,
        output mem_resp, pmem_read, pmem_write, data_in_sel, pmem_addr_sel,
               wr_en_data_0_sel, wr_en_data_1_sel, dirty_in, valid_in,
               ld_dirty_0, ld_dirty_1, ld_valid_0, ld_valid_1,
               ld_tag_0, ld_tag_1, ld_lru
    );

    // Environment side (CPU, adapter, datapath)
    modport slave (
        output mem_read, mem_write, pmem_resp, miss, dirty_out, way,
        input  mem_resp, pmem_read, pmem_write, data_in_sel, pmem_addr_sel,
               wr_en_data_0_sel, wr_en_data_1_sel, dirty_in, valid_in,
               ld_dirty_0, ld_dirty_1, ld_valid_0, ld_valid_1,
               ld_tag_0, ld_tag_1, ld_lru
    );
endinterface

// File: rtl/new_cache_control.sv
// Cache controller FSM: hit service, dirty-line writeback and line fill for a
// 2-way, 8-set, 32-byte-line cache. Outputs are forced low while rst is high.
module new_cache_control
    import new_cache_types::*;
(
    input  logic                clk,
    input  logic                rst,
    new_cache_control_if.master bus
);

    state_e          state_q;
    state_e          state_d;
    logic            req;
    logic [1:0][1:0] wr_sel_v;
    logic [1:0]      ld_dirty_v;
    logic [1:0]      ld_valid_v;
    logic [1:0]      ld_tag_v;

    // A simultaneous read and write is serviced as a write.
    assign req = bus.mem_read | bus.mem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!req || !bus.miss) state_d = S_IDLE;
                else if (bus.dirty_out) state_d = S_WRITEBACK;
                else state_d = S_FETCH;
            end
            S_WRITEBACK: begin
                if (bus.pmem_resp) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.pmem_resp) state_d = S_CHECK;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin : outputs
        bus.mem_resp      = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.data_in_sel   = 1'b0;
        bus.pmem_addr_sel = 1'b0;
        bus.dirty_in      = 1'b0;
        bus.valid_in      = 1'b0;
        bus.ld_lru        = 1'b0;
        wr_sel_v          = {WREN_NONE, WREN_NONE};
        ld_dirty_v        = 2'b00;
        ld_valid_v        = 2'b00;
        ld_tag_v          = 2'b00;
        if (!rst) begin
            case (state_q)
                S_CHECK: begin
                    if (req && !bus.miss) begin
                        bus.mem_resp = 1'b1;
                        bus.ld_lru   = 1'b1;
                        if (bus.mem_write) begin
                            bus.data_in_sel     = 1'b1;
                            bus.dirty_in        = 1'b1;
                            wr_sel_v[bus.way]   = WREN_BYTE;
                            ld_dirty_v[bus.way] = 1'b1;
                        end
                    end
                end
                S_WRITEBACK: begin
                    bus.pmem_write = 1'b1;
                    if (bus.pmem_resp) ld_dirty_v[bus.way] = 1'b1;
                end
                S_FETCH: begin
                    bus.pmem_read     = 1'b1;
                    bus.pmem_addr_sel = 1'b1;
                    // The filled line arrives clean and valid in the victim way.
                    if (bus.pmem_resp) begin
                        bus.valid_in        = 1'b1;
                        wr_sel_v[bus.way]   = WREN_ALL;
                        ld_tag_v[bus.way]   = 1'b1;
                        ld_valid_v[bus.way] = 1'b1;
                        ld_dirty_v[bus.way] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.wr_en_data_0_sel = wr_sel_v[0];
    assign bus.wr_en_data_1_sel = wr_sel_v[1];
    assign bus.ld_dirty_0       = ld_dirty_v[0];
    assign bus.ld_dirty_1       = ld_dirty_v[1];
    assign bus.ld_valid_0       = ld_valid_v[0];
    assign bus.ld_valid_1       = ld_valid_v[1];
    assign bus.ld_tag_0         = ld_tag_v[0];
    assign bus.ld_tag_1         = ld_tag_v[1];

endmodule

// File: tb/tb_new_cache_control.sv
// Bench for new_cache_control: behavioural datapath and cacheline adapter,
// transaction-level cache model feeding a scoreboard checked by a monitor.
module tb_new_cache_control;

    localparam logic [17:0] V_RESP = 18'h20000;
    localparam logic [17:0] V_PR   = 18'h10000;
    localparam logic [17:0] V_PW   = 18'h08000;
    localparam logic [17:0] V_DIS  = 18'h04000;
    localparam logic [17:0] V_AS   = 18'h02000;
    localparam logic [17:0] V_DI   = 18'h00100;
    localparam logic [17:0] V_VI   = 18'h00080;
    localparam logic [17:0] V_LRU  = 18'h00001;

    typedef struct {
        int has_resp;
        int lat;
        int resp_vec;
        int wb_cyc;
        int wb_vec;
        int fe_cyc;
        int fe_vec;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    new_cache_control_if bus();

    new_cache_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic done_req = 1'b0;
    logic fin = 1'b0;
    logic spur = 1'b0;
    logic adapter_resp = 1'b0;
    int   wb_delay = 1;
    int   fe_delay = 1;
    logic [31:0] cur_addr = 32'h0;

    // ---------------- behavioural datapath (driven by DUT strobes) --------
    logic [23:0] dp_tag   [8][2];
    logic        dp_valid [8][2];
    logic        dp_dirty [8][2];
    logic        dp_lru   [8];
    wire  [2:0]  cur_set = cur_addr[7:5];
    wire  [23:0] cur_tag = cur_addr[31:8];
    wire         hit0 = dp_valid[cur_set][0] && (dp_tag[cur_set][0] == cur_tag);
    wire         hit1 = dp_valid[cur_set][1] && (dp_tag[cur_set][1] == cur_tag);
    wire         sel_way = hit0 ? 1'b0 : (hit1 ? 1'b1 : dp_lru[cur_set]);

    assign bus.miss      = !(hit0 || hit1);
    assign bus.way       = sel_way;
    assign bus.dirty_out = dp_dirty[cur_set][sel_way];
    assign bus.pmem_resp = adapter_resp | spur;

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 8; s++) begin
                dp_lru[s] <= 1'b0;
                for (int w = 0; w < 2; w++) begin
                    dp_tag[s][w]   <= '0;
                    dp_valid[s][w] <= 1'b0;
                    dp_dirty[s][w] <= 1'b0;
                end
            end
        end else begin
            if (bus.ld_tag_0)   dp_tag[cur_set][0]   <= cur_tag;
            if (bus.ld_tag_1)   dp_tag[cur_set][1]   <= cur_tag;
            if (bus.ld_valid_0) dp_valid[cur_set][0] <= bus.valid_in;
            if (bus.ld_valid_1) dp_valid[cur_set][1] <= bus.valid_in;
            if (bus.ld_dirty_0) dp_dirty[cur_set][0] <= bus.dirty_in;
            if (bus.ld_dirty_1) dp_dirty[cur_set][1] <= bus.dirty_in;
            if (bus.ld_lru)     dp_lru[cur_set]      <= ~sel_way;
        end
    end

    // ---------------- cacheline adapter: responds after a chosen delay ----
    initial begin
        int cnt;
        logic [1:0] cur;
        logic [1:0] prev;
        cnt = 0;
        prev = 2'b00;
        forever begin
            @(posedge clk);
            #2;
            cur = {bus.pmem_read, bus.pmem_write};
            if (cur == 2'b00) cnt = 0;
            else if (cur != prev) cnt = 1;
            else cnt++;
            prev = cur;
            adapter_resp = ((cur == 2'b10) && (cnt == fe_delay)) ||
                           ((cur == 2'b01) && (cnt == wb_delay));
        end
    end

    // ---------------- transaction-level reference cache ------------------
    bit [23:0] m_tag   [8][2];
    bit        m_valid [8][2];
    bit        m_dirty [8][2];
    bit        m_lru   [8];

    function automatic logic [17:0] wr_bits(input bit w, input logic [1:0] code);
        logic [17:0] v;
        v = '0;
        if (w) v[10:9] = code;
        else   v[12:11] = code;
        return v;
    endfunction

    function automatic logic [17:0] ld_d(input bit w);
        return w ? 18'h00020 : 18'h00040;
    endfunction

    function automatic logic [17:0] ld_v(input bit w);
        return w ? 18'h00008 : 18'h00010;
    endfunction

    function automatic logic [17:0] ld_t(input bit w);
        return w ? 18'h00002 : 18'h00004;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 8; s++) begin
            m_lru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                m_tag[s][w] = '0;
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
    endtask

    // Expected behaviour of one CPU access; drop means the CPU abandons it.
    task automatic predict(input logic [31:0] a, input bit wr, input bit drop,
                           input int wd, input int fd, output exp_t e);
        int s;
        bit [23:0] t;
        bit hit, w, wb;
        s = int'(a[7:5]);
        t = a[31:8];
        hit = 1'b0;
        w = m_lru[s];
        for (int k = 0; k < 2; k++) begin
            if (m_valid[s][k] && m_tag[s][k] == t) begin
                hit = 1'b1;
                w = k[0];
            end
        end
        wb = !hit && m_dirty[s][w];
        e.has_resp = 0; e.lat = 0; e.resp_vec = 0;
        e.wb_cyc = 0; e.wb_vec = 0; e.fe_cyc = 0; e.fe_vec = 0;
        if (!hit) begin
            if (wb) begin
                e.wb_cyc = wd;
                e.wb_vec = int'(V_PW | ld_d(w));
            end
            e.fe_cyc = fd;
            e.fe_vec = int'(V_PR | V_AS | V_VI | wr_bits(w, 2'b01) | ld_t(w) | ld_v(w) | ld_d(w));
            m_tag[s][w] = t;
            m_valid[s][w] = 1'b1;
            m_dirty[s][w] = 1'b0;
        end
        if (!drop) begin
            e.has_resp = 1;
            e.lat = hit ? 1 : 2 + fd + (wb ? wd : 0);
            e.resp_vec = int'(V_RESP | V_LRU);
            if (wr) begin
                e.resp_vec = int'(V_RESP | V_LRU | V_DIS | V_DI | wr_bits(w, 2'b10) | ld_d(w));
                m_dirty[s][w] = 1'b1;
            end
            m_lru[s] = ~w;
        end
    endtask

    // ---------------- stimulus -----------------------------------------
    task automatic end_txn();
        @(posedge clk); #1;
        done_req = 1'b1;
        @(posedge clk); #1;
        done_req = 1'b0;
    endtask

    task automatic do_txn(input logic [31:0] a, input bit rd, input bit wr,
                          input int wd, input int fd);
        exp_t e;
        bit got;
        int n;
        predict(a, wr, 1'b0, wd, fd, e);
        exp_q.push_back(e);
        wb_delay = wd;
        fe_delay = fd;
        @(posedge clk); #1;
        cur_addr = a;
        bus.mem_read = rd;
        bus.mem_write = wr;
        spur = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        spur = 1'b0;
        got = 1'b0;
        n = 0;
        while (!got && n < 300) begin
            @(negedge clk);
            got = bus.mem_resp;
            n++;
        end
        @(posedge clk); #1;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        if (!got) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            model_clear();
        end
        end_txn();
    endtask

    initial begin
        exp_t e;
        logic [31:0] a;
        int rw;
        rst = 1'b1;
        bus.mem_read = 1'b1;
        bus.mem_write = 1'b0;
        model_clear();
        e.has_resp = 0; e.lat = 0; e.resp_vec = 0;
        e.wb_cyc = 0; e.wb_vec = 0; e.fe_cyc = 0; e.fe_vec = 0;
        exp_q.push_back(e);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.mem_read = 1'b0;
        @(posedge clk); #1;
        end_txn();

        do_txn(32'h0000_0040, 1'b1, 1'b0, 1, 3);
        do_txn(32'h0000_0040, 1'b1, 1'b0, 1, 3);
        do_txn(32'h0000_0040, 1'b0, 1'b1, 1, 3);
        do_txn(32'h0000_0140, 1'b0, 1'b1, 2, 3);
        do_txn(32'h0000_0240, 1'b1, 1'b0, 5, 4);

        // CPU drops a read while the fill is in flight.
        predict(32'h0000_00C0, 1'b0, 1'b1, 1, 4, e);
        exp_q.push_back(e);
        fe_delay = 4;
        @(posedge clk); #1;
        cur_addr = 32'h0000_00C0;
        bus.mem_read = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.mem_read = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        end_txn();

        // Reset in the third FETCH cycle, then stray adapter responses.
        e.has_resp = 0; e.lat = 0; e.resp_vec = 0;
        e.wb_cyc = 0; e.wb_vec = 0; e.fe_cyc = 2; e.fe_vec = 0;
        exp_q.push_back(e);
        fe_delay = 20;
        @(posedge clk); #1;
        cur_addr = 32'h0000_00A0;
        bus.mem_read = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.mem_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        @(posedge clk); #1; spur = 1'b1;
        @(posedge clk); #1; spur = 1'b0;
        @(posedge clk); #1; spur = 1'b1;
        @(posedge clk); #1; spur = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        end_txn();

        for (int i = 0; i < 60; i++) begin
            a = ({8'h0, 24'($urandom_range(0, 3))} << 8) |
                (32'($urandom_range(0, 3)) << 5) | 32'($urandom_range(0, 31));
            rw = $urandom_range(0, 3);
            do_txn(a, (rw != 2), (rw >= 2), $urandom_range(1, 6), $urandom_range(1, 6));
        end

        @(posedge clk); #1;
        fin = 1'b1;
    end

    // ---------------- monitor / scoreboard ------------------------------
    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    initial begin
        logic [17:0] v;
        exp_t e;
        bit active;
        int cyc, o_resp, o_lat, o_resp_vec, o_wb, o_wb_vec, o_fe, o_fe_vec, stray, txn;
        active = 0; cyc = 0; o_resp = 0; o_lat = 0; o_resp_vec = 0;
        o_wb = 0; o_wb_vec = 0; o_fe = 0; o_fe_vec = 0; stray = 0; txn = 0;
        forever begin
            @(negedge clk);
            if (fin) begin
                check("queue_empty", exp_q.size(), 0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end else if (done_req) begin
                if (exp_q.size() == 0) begin
                    check("queue_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_count", o_resp, e.has_resp);
                    if (e.has_resp != 0) begin
                        check("resp_latency", o_lat, e.lat);
                        check("resp_outputs", o_resp_vec, e.resp_vec);
                    end
                    check("wb_cycles", o_wb, e.wb_cyc);
                    check("wb_resp_outputs", o_wb_vec, e.wb_vec);
                    check("fetch_cycles", o_fe, e.fe_cyc);
                    check("fetch_resp_outputs", o_fe_vec, e.fe_vec);
                    check("stray_outputs", stray, 0);
                    $display("txn %0d resp=%0d lat=%0d wb=%0d fetch=%0d", txn, o_resp, o_lat, o_wb, o_fe);
                end
                txn++;
                active = 0; cyc = 0; o_resp = 0; o_lat = 0; o_resp_vec = 0;
                o_wb = 0; o_wb_vec = 0; o_fe = 0; o_fe_vec = 0; stray = 0;
            end else begin
                v = {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.data_in_sel,
                     bus.pmem_addr_sel, bus.wr_en_data_0_sel, bus.wr_en_data_1_sel,
                     bus.dirty_in, bus.valid_in, bus.ld_dirty_0, bus.ld_dirty_1,
                     bus.ld_valid_0, bus.ld_valid_1, bus.ld_tag_0, bus.ld_tag_1, bus.ld_lru};
                if (!active && (bus.mem_read || bus.mem_write)) begin
                    active = 1;
                    cyc = 0;
                end
                if (v[17]) begin
                    o_resp++;
                    o_lat = cyc;
                    o_resp_vec = int'(v);
                end else if (v[15] && !v[16]) begin
                    o_wb++;
                    if (bus.pmem_resp) o_wb_vec = int'(v);
                    else if (v != V_PW) stray++;
                end else if (v[16] && !v[15]) begin
                    o_fe++;
                    if (bus.pmem_resp) o_fe_vec = int'(v);
                    else if (v != (V_PR | V_AS)) stray++;
                end else if (v != 18'h0) begin
                    stray++;
                end
                if (active) cyc++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
